// File: rtl/at_cmd_sequencer_pkg.sv
// Shared definitions for the GSM modem AT command sequencer: response codes,
// FSM states, command indices and ASCII constants.
package at_pkg;

    localparam logic [2:0] RSP_NONE   = 3'd0;
    localparam logic [2:0] RSP_OK     = 3'd1;
    localparam logic [2:0] RSP_STORE  = 3'd2;
    localparam logic [2:0] RSP_ERR    = 3'd3;
    localparam logic [2:0] RSP_NEWMSG = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_READY,
        ST_FAIL
    } state_t;

    localparam logic [1:0] CMD_AT   = 2'd0;
    localparam logic [1:0] CMD_CMGF = 2'd1;
    localparam logic [1:0] CMD_CPMS = 2'd2;
    localparam logic [1:0] CMD_CMGR = 2'd3;

    localparam logic [7:0] CR = 8'h0D;

    // Only the storage-select command answers with its own code; the rest answer OK.
    function automatic logic [2:0] expected_rsp(input logic [1:0] cmd);
        return (cmd == CMD_CPMS) ? RSP_STORE : RSP_OK;
    endfunction

endpackage

// File: rtl/at_cmd_rom.sv
// Fixed AT command table: returns the byte at (cmd_idx, byte_idx) and flags the
// final carriage return of each command.
module at_cmd_rom
    import at_pkg::*;
(
    input  logic [1:0] cmd_idx,
    input  logic [3:0] byte_idx,
    input  logic [7:0] msg_no,
    output logic [7:0] cmd_byte,
    output logic       last
);

    localparam int STR_W = 104;

    logic [STR_W-1:0] str;
    logic [STR_W-1:0] str_sh;
    logic [3:0]       last_idx;

    // Each command is left-justified in a 13-byte window; byte_idx shifts it out MSB first.
    always_comb begin
        str      = '0;
        last_idx = 4'd0;
        case (cmd_idx)
            CMD_AT: begin
                str      = {"AT", CR, 80'h0};
                last_idx = 4'd2;
            end
            CMD_CMGF: begin
                str      = {"AT+CMGF=1", CR, 24'h0};
                last_idx = 4'd9;
            end
            CMD_CPMS: begin
                str      = {"AT+CPMS=\"SM\"", CR};
                last_idx = 4'd12;
            end
            default: begin
                str      = {"AT+CMGR=", msg_no, CR, 24'h0};
                last_idx = 4'd9;
            end
        endcase
        str_sh   = str << {byte_idx, 3'b000};
        cmd_byte = str_sh[STR_W-1 -: 8];
        last     = (byte_idx == last_idx);
    end

endmodule

// File: rtl/at_cmd_sequencer.sv
// Drives the modem boot script and SIM message reads over the UART, with
// response timeout, bounded retries and a one-deep new-message pending slot.
module at_cmd_sequencer
    import at_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100_000_000,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 27
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       rsp_valid,
    input  logic [2:0] rsp_code,
    input  logic [7:0] rsp_msg_no,
    output logic       init_done,
    output logic       busy,
    output logic       fail,
    output logic       rd_active,
    output logic       rd_done,
    output logic [7:0] rd_msg_no,
    output logic [3:0] lost_cnt
);

    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    state_t           state_reg, state_next;
    logic [1:0]       cmd_reg, cmd_next;
    logic [3:0]       byte_reg, byte_next;
    logic [RTY_W-1:0] retry_reg, retry_next;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic             pend_valid_reg, pend_valid_next;
    logic [7:0]       pend_no_reg, pend_no_next;
    logic [3:0]       lost_reg, lost_next;
    logic             init_done_reg, init_done_next;
    logic             fail_reg, fail_next;
    logic             rd_active_reg, rd_active_next;
    logic             rd_done_reg, rd_done_next;
    logic [7:0]       rd_msg_no_reg, rd_msg_no_next;

    logic [7:0]       rom_byte;
    logic             rom_last;
    logic [RTY_W-1:0] retry_inc;
    logic             notif;
    logic             consume;
    logic             clear_notif;

    at_cmd_rom u_rom (
        .cmd_idx  (cmd_reg),
        .byte_idx (byte_reg),
        .msg_no   (rd_msg_no_reg),
        .cmd_byte (rom_byte),
        .last     (rom_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cmd_reg        <= CMD_AT;
            byte_reg       <= '0;
            retry_reg      <= '0;
            timer_reg      <= '0;
            pend_valid_reg <= 1'b0;
            pend_no_reg    <= 8'h00;
            lost_reg       <= 4'd0;
            init_done_reg  <= 1'b0;
            fail_reg       <= 1'b0;
            rd_active_reg  <= 1'b0;
            rd_done_reg    <= 1'b0;
            rd_msg_no_reg  <= 8'h00;
        end else begin
            state_reg      <= state_next;
            cmd_reg        <= cmd_next;
            byte_reg       <= byte_next;
            retry_reg      <= retry_next;
            timer_reg      <= timer_next;
            pend_valid_reg <= pend_valid_next;
            pend_no_reg    <= pend_no_next;
            lost_reg       <= lost_next;
            init_done_reg  <= init_done_next;
            fail_reg       <= fail_next;
            rd_active_reg  <= rd_active_next;
            rd_done_reg    <= rd_done_next;
            rd_msg_no_reg  <= rd_msg_no_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cmd_next        = cmd_reg;
        byte_next       = byte_reg;
        retry_next      = retry_reg;
        timer_next      = timer_reg;
        pend_valid_next = pend_valid_reg;
        pend_no_next    = pend_no_reg;
        lost_next       = lost_reg;
        init_done_next  = init_done_reg;
        fail_next       = fail_reg;
        rd_active_next  = rd_active_reg;
        rd_done_next    = 1'b0;
        rd_msg_no_next  = rd_msg_no_reg;
        retry_inc       = retry_reg + 1'b1;
        notif           = rsp_valid && (rsp_code == RSP_NEWMSG);
        consume         = 1'b0;
        clear_notif     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SEND;
                    cmd_next   = CMD_AT;
                    byte_next  = '0;
                    retry_next = '0;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (rom_last) begin
                        state_next = ST_WAIT;
                        timer_next = '0;
                    end else begin
                        byte_next = byte_reg + 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                timer_next = timer_reg + 1'b1;
                // A matching response takes priority over a timeout in the same cycle.
                if (rsp_valid && (rsp_code == expected_rsp(cmd_reg))) begin
                    case (cmd_reg)
                        CMD_AT, CMD_CMGF: begin
                            state_next = ST_SEND;
                            cmd_next   = cmd_reg + 2'd1;
                            byte_next  = '0;
                            retry_next = '0;
                        end
                        CMD_CPMS: begin
                            state_next     = ST_READY;
                            init_done_next = 1'b1;
                        end
                        default: begin
                            state_next     = ST_READY;
                            rd_done_next   = 1'b1;
                            rd_active_next = 1'b0;
                        end
                    endcase
                end else if ((rsp_valid && (rsp_code == RSP_ERR)) || (timer_reg == TMO_LAST)) begin
                    retry_next = retry_inc;
                    if (retry_inc < RTY_MAX) begin
                        state_next = ST_SEND;
                        byte_next  = '0;
                    end else begin
                        state_next     = ST_FAIL;
                        fail_next      = 1'b1;
                        init_done_next = 1'b0;
                        rd_active_next = 1'b0;
                    end
                end
            end
            ST_READY: begin
                if (pend_valid_reg) begin
                    consume        = 1'b1;
                    rd_msg_no_next = pend_no_reg;
                    rd_active_next = 1'b1;
                    state_next     = ST_SEND;
                    cmd_next       = CMD_CMGR;
                    byte_next      = '0;
                    retry_next     = '0;
                end
            end
            ST_FAIL: begin
                if (start) begin
                    clear_notif = 1'b1;
                    fail_next   = 1'b0;
                    state_next  = ST_SEND;
                    cmd_next    = CMD_AT;
                    byte_next   = '0;
                    retry_next  = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A notification landing on an unserved one replaces it and counts as lost.
        if (clear_notif) begin
            pend_valid_next = 1'b0;
            lost_next       = 4'd0;
        end else begin
            if (consume) begin
                pend_valid_next = 1'b0;
            end
            if (notif && (state_reg != ST_FAIL)) begin
                pend_valid_next = 1'b1;
                pend_no_next    = rsp_msg_no;
                if (pend_valid_reg && !consume && (lost_reg != 4'hF)) begin
                    lost_next = lost_reg + 4'd1;
                end
            end
        end
    end

    assign tx_valid  = (state_reg == ST_SEND);
    assign tx_data   = tx_valid ? rom_byte : 8'h00;
    assign busy      = (state_reg == ST_SEND) || (state_reg == ST_WAIT);
    assign init_done = init_done_reg;
    assign fail      = fail_reg;
    assign rd_active = rd_active_reg;
    assign rd_done   = rd_done_reg;
    assign rd_msg_no = rd_msg_no_reg;
    assign lost_cnt  = lost_reg;

endmodule

// File: tb/tb_at_cmd_sequencer.sv
// Directed bench for at_cmd_sequencer: a response table covering boot, retry
// and message reads, plus sequences for backpressure, async reset and timeout.
module tb_at_cmd_sequencer;
    import at_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       rsp_valid;
    logic [2:0] rsp_code;
    logic [7:0] rsp_msg_no;
    logic       init_done;
    logic       busy;
    logic       fail;
    logic       rd_active;
    logic       rd_done;
    logic [7:0] rd_msg_no;
    logic [3:0] lost_cnt;

    int         total = 0;
    int         bad = 0;
    logic [7:0] txq[$];
    int         rd_gap;
    int         hold_err;
    int         stall_cnt;
    bit         bp = 1'b0;

    typedef struct {
        int         cmd;
        logic [2:0] code;
        logic [7:0] no;
        logic       init;
        logic       bsy;
        logic       fl;
        logic       rdd;
        logic       rda;
        logic [7:0] rd_no;
        logic [3:0] lost;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    at_cmd_sequencer #(
        .TIMEOUT_CYC (50),
        .MAX_RETRY   (3),
        .CNT_W       (27)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rsp_valid  (rsp_valid),
        .rsp_code   (rsp_code),
        .rsp_msg_no (rsp_msg_no),
        .init_done  (init_done),
        .busy       (busy),
        .fail       (fail),
        .rd_active  (rd_active),
        .rd_done    (rd_done),
        .rd_msg_no  (rd_msg_no),
        .lost_cnt   (lost_cnt)
    );

    function automatic string cmd_text(int c, logic [7:0] no);
        case (c)
            0:       return "AT\r";
            1:       return "AT+CMGF=1\r";
            2:       return "AT+CPMS=\"SM\"\r";
            default: return $sformatf("AT+CMGR=%c\r", no);
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: records the byte the transmitter accepts and any change of tx_data during a stall.
    task automatic tick();
        logic       acc;
        logic       stall;
        logic       ra;
        logic [7:0] b;
        acc   = tx_valid && tx_ready;
        stall = tx_valid && !tx_ready;
        ra    = rd_active;
        b     = tx_data;
        @(posedge clk);
        #1;
        if (acc) begin
            txq.push_back(b);
            if (!ra) rd_gap++;
        end
        if (stall) begin
            stall_cnt++;
            if (tx_valid && (tx_data !== b)) hold_err++;
        end
        if (bp) tx_ready = ~tx_ready;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_rsp(logic [2:0] c, logic [7:0] n);
        rsp_valid  = 1'b1;
        rsp_code   = c;
        rsp_msg_no = n;
        tick();
        rsp_valid  = 1'b0;
        rsp_code   = RSP_NONE;
    endtask

    task automatic check_txq(string name, string exp);
        bit    ok;
        string got;
        ok  = (txq.size() == exp.len());
        got = "";
        foreach (txq[i]) begin
            if (i < exp.len() && txq[i] !== exp[i]) ok = 1'b0;
            if (i < 16) got = {got, $sformatf("%02h ", txq[i])};
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d bytes [%s] expected %0d bytes of %s",
                     name, txq.size(), got, exp.len(), exp);
        end
    endtask

    // Runs the transmitter until the sequencer waits for a response, then checks the bytes sent.
    task automatic collect(string name, string exp);
        int n;
        n = 0;
        txq.delete();
        rd_gap = 0;
        while (!(busy && !tx_valid) && n < 300) begin
            tick();
            n++;
        end
        chk({name, " reached wait"}, 32'(busy && !tx_valid), 1);
        check_txq(name, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n      = 1'b0;
        start      = 1'b0;
        tx_ready   = 1'b1;
        rsp_valid  = 1'b0;
        rsp_code   = RSP_NONE;
        rsp_msg_no = 8'h00;

        vecs[0]  = '{0,  RSP_ERR,    8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        vecs[1]  = '{0,  RSP_ERR,    8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        vecs[2]  = '{0,  RSP_OK,     8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        vecs[3]  = '{1,  RSP_STORE,  8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        vecs[4]  = '{-1, RSP_OK,     8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        vecs[5]  = '{2,  RSP_NEWMSG, 8'h31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        vecs[6]  = '{-1, RSP_NEWMSG, 8'h32, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd1};
        vecs[7]  = '{-1, RSP_STORE,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd1};
        vecs[8]  = '{3,  RSP_OK,     8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h32, 4'd1};
        vecs[9]  = '{-1, RSP_NEWMSG, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h32, 4'd1};
        vecs[10] = '{3,  RSP_OK,     8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 4'd1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset tx_valid", 32'(tx_valid), 0);
        chk("reset tx_data", 32'(tx_data), 0);
        chk("reset init_done", 32'(init_done), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset fail", 32'(fail), 0);
        chk("reset rd_active", 32'(rd_active), 0);
        chk("reset rd_done", 32'(rd_done), 0);
        chk("reset rd_msg_no", 32'(rd_msg_no), 0);
        chk("reset lost_cnt", 32'(lost_cnt), 0);
        rst_n = 1'b1;
        txq.delete();
        repeat (5) tick();
        chk("idle sends nothing", 32'(txq.size()), 0);
        chk("idle busy", 32'(busy), 0);

        // Boot with two ERROR retries, ignored codes, two notifications and two reads.
        pulse_start();
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].cmd >= 0) begin
                collect($sformatf("row%0d tx", i), cmd_text(vecs[i].cmd, vecs[i].rd_no));
                if (vecs[i].cmd == 3) chk($sformatf("row%0d rd_active during read", i), rd_gap, 0);
            end
            send_rsp(vecs[i].code, vecs[i].no);
            chk($sformatf("row%0d init_done", i), 32'(init_done), 32'(vecs[i].init));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
            chk($sformatf("row%0d fail", i), 32'(fail), 32'(vecs[i].fl));
            chk($sformatf("row%0d rd_done", i), 32'(rd_done), 32'(vecs[i].rdd));
            chk($sformatf("row%0d rd_active", i), 32'(rd_active), 32'(vecs[i].rda));
            chk($sformatf("row%0d rd_msg_no", i), 32'(rd_msg_no), 32'(vecs[i].rd_no));
            chk($sformatf("row%0d lost_cnt", i), 32'(lost_cnt), 32'(vecs[i].lost));
        end
        tick();
        chk("rd_done one cycle", 32'(rd_done), 0);
        repeat (3) tick();
        chk("no extra read busy", 32'(busy), 0);
        chk("no extra read tx_valid", 32'(tx_valid), 0);

        // Backpressure on the second command: ready toggles every cycle.
        do_reset();
        pulse_start();
        collect("bp C0", "AT\r");
        send_rsp(RSP_OK, 8'h00);
        hold_err  = 0;
        stall_cnt = 0;
        tx_ready  = 1'b0;
        bp        = 1'b1;
        collect("bp C1", "AT+CMGF=1\r");
        bp        = 1'b0;
        tx_ready  = 1'b1;
        chk("bp tx_data held", hold_err, 0);
        chk("bp stall count", stall_cnt, 10);

        // Asynchronous reset in the middle of the second command.
        do_reset();
        pulse_start();
        collect("rst C0", "AT\r");
        send_rsp(RSP_OK, 8'h00);
        txq.delete();
        w = 0;
        while (txq.size() < 5 && w < 50) begin
            tick();
            w++;
        end
        chk("rst byte5 data", 32'(tx_data), 32'h47);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async tx_valid", 32'(tx_valid), 0);
        chk("rst async tx_data", 32'(tx_data), 0);
        chk("rst async busy", 32'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        txq.delete();
        repeat (10) tick();
        chk("rst no resume bytes", 32'(txq.size()), 0);
        chk("rst no resume tx_valid", 32'(tx_valid), 0);

        // Silent modem: three timeouts of 50 wait cycles each, then sticky failure.
        do_reset();
        pulse_start();
        collect("to try0", "AT\r");
        for (int a = 0; a < 3; a++) begin
            w = 0;
            while (busy && !tx_valid && w < 200) begin
                tick();
                w++;
            end
            chk($sformatf("to wait cycles %0d", a), w, 50);
            if (a < 2) collect($sformatf("to try%0d", a + 1), "AT\r");
        end
        chk("to fail", 32'(fail), 1);
        chk("to tx_valid", 32'(tx_valid), 0);
        chk("to busy", 32'(busy), 0);
        txq.delete();
        repeat (20) tick();
        chk("to fail sticky", 32'(fail), 1);
        chk("to silent in fail", 32'(txq.size()), 0);
        pulse_start();
        chk("to restart clears fail", 32'(fail), 0);
        collect("to restart C0", "AT\r");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/at_cmd_sequencer.md
Name: at_cmd_sequencer

Overview:
- Sequences the GSM modem over the UART link.
- Issues the boot command script byte-by-byte to the UART transmitter, then waits for each response code from the AT response parser.
- After init it idles. On a new-message indication it issues the read command for that SIM slot and flags the read window to the message-capture logic.
- Handles ERROR responses and timeouts with bounded retries.

Parameters:
- TIMEOUT_CYC, 100_000_000, cycles allowed between the last command byte accepted and a matching response (1 s at 100 MHz).
- MAX_RETRY, 3, attempts per command before declaring failure.
- CNT_W, 27, width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; (re)starts the boot script from IDLE or FAIL, ignored elsewhere
- tx_data  out  8  ASCII byte to the UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts the byte when tx_valid&&tx_ready
- rsp_valid  in  1  one-cycle strobe, parser result available
- rsp_code  in  3  0 none, 1 OK, 2 storage set, 3 ERROR, 4 new message
- rsp_msg_no  in  8  ASCII digit of the SIM slot, valid with rsp_code==4
- init_done  out  1  boot script completed
- busy  out  1  a command is in flight (SEND or WAIT)
- fail  out  1  sticky; retries exhausted
- rd_active  out  1  high from the first read-command byte until its response
- rd_done  out  1  one-cycle pulse on the read command's OK
- rd_msg_no  out  8  slot currently or last read
- lost_cnt  out  4  saturating count of overwritten pending notifications

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, except tx_data=8'h00 and rd_msg_no=8'h00. Retry count, byte index, pending flag and timer are cleared.
- Command table, fixed and indexed 0..3:
  - C0 "AT\r", expects code 1.
  - C1 "AT+CMGF=1\r", expects code 1.
  - C2 "AT+CPMS=\"SM\"\r", expects code 2.
  - C3 "AT+CMGR=" followed by the rd_msg_no byte and 8'h0D, expects code 1.
- States: IDLE, SEND, WAIT, READY, FAIL.
- IDLE: start → SEND with C0, retry=0.
- SEND:
  - tx_valid=1 and tx_data=the current byte.
  - The index advances only on the tx_valid&&tx_ready cycle. tx_data is held stable while stalled.
  - After the acceptance of the last byte (0x0D), next cycle → WAIT, timer=0.
  - Zero-latency: the first byte is presented in the cycle after entry to SEND.
- WAIT: the timer increments every cycle.
  - On rsp_valid with the expected code:
    - C0→C1, C1→C2, each via SEND with retry=0.
    - C2 → READY with init_done=1.
    - C3 → READY with rd_done pulse and rd_active=0.
  - On rsp_valid with code 3, or timer==TIMEOUT_CYC-1: retry+1. If retry+1<MAX_RETRY, resend the same command from byte 0; else → FAIL with fail=1, init_done=0, rd_active=0.
  - rsp_valid coinciding with the timeout cycle: the response wins.
  - Other codes in WAIT are ignored, except code 4, which is latched as pending.
- Notifications (code 4):
  - In any state except FAIL, latch rsp_msg_no into a one-deep pending register.
  - If pending is already set, overwrite it and increment lost_cnt (saturating at 15).
- READY:
  - If pending: rd_msg_no←pending value, clear pending, → SEND C3, rd_active=1.
  - A notification arriving in READY itself is served next cycle.
- FAIL: tx_valid=0, sticky. start → IDLE-equivalent restart to SEND C0, clearing fail, pending and lost_cnt.
- start in SEND/WAIT/READY is ignored.
- busy = (state==SEND || state==WAIT).
- Reset mid-transmission: tx_valid drops immediately (async), with no partial resume.

Decomposition:
- Shared package `at_pkg`:
  - rsp_code constants (RSP_NONE/OK/STORE/ERR/NEWMSG).
  - state encoding.
  - command-index constants.
  - ASCII constants CR=8'h0D.
- Sub-module `at_cmd_rom`: combinational (cmd_idx, byte_idx, msg_no) → (byte, last).
- The sequencer owns only the FSM, timer, retry count and pending logic.

Test Plan:
- Boot: pulse start, tx_ready=1, reply OK, OK, code 2.
  - Byte stream must be 41 54 0D, then "AT+CMGF=1\r", then "AT+CPMS=\"SM\"\r".
  - init_done=1 exactly one cycle after the code-2 strobe; busy=0.
- Backpressure: toggle tx_ready 1/0 every cycle during C1.
  - tx_data must hold while tx_ready=0.
  - Exactly 10 bytes accepted; no duplicates or skips.
- Retry: reply ERROR to C0 twice, then OK.
  - "AT\r" transmitted 3 times; proceeds to C1; fail=0.
- Timeout: with TIMEOUT_CYC=50, send no response.
  - 3 transmissions of C0 spaced by ≥50 cycles of WAIT.
  - fail=1 after the third timeout; tx_valid=0 thereafter; start restarts C0.
- New message: in READY, rsp_code=4 with rsp_msg_no=8'h33.
  - Bytes "AT+CMGR=" 33 0D; rd_active=1 throughout.
  - OK → rd_done pulse, rd_msg_no=8'h33.
  - Two notifications (8'h31, 8'h32) during C2 WAIT → reads slot 8'h32 only, lost_cnt=1.
- Reset mid-operation: assert rst_n=0 during byte 5 of C1.
  - All outputs return to reset values asynchronously.
  - After release, nothing is sent until start.
